// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round sequencer for the button guessing game.
// Gates the selected speed tick into the guess FSM, clears that FSM between
// rounds, holds each round result for HOLD_TICKS slow ticks, keeps a
// win/loss score over a MATCH_ROUNDS match and selects the difficulty.
// Optional feature macro: GAME_AUTO_HARD_EN (win-streak driven hard mode).
// state_dbg exposes the FSM state (0 IDLE, 1 PLAY, 2 RESULT, 3 DONE).
module game_round_ctrl #(
    parameter int SCORE_W      = 4,
    parameter int MATCH_ROUNDS = 9,
    parameter int HOLD_TICKS   = 3,
    parameter int WIN_STREAK   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               en_slow,
    input  logic               en_fast,
    input  logic               hard_sw,
    input  logic               win,
    input  logic               lose,
    output logic               fsm_en,
    output logic               fsm_clr,
    output logic               playing,
    output logic [1:0]         result,
    output logic               hard_mode,
    output logic [SCORE_W-1:0] wins,
    output logic [SCORE_W-1:0] losses,
    output logic [1:0]         state_dbg
);

    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        RESULT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q;
    logic [SCORE_W-1:0] round_cnt_q;
    logic               auto_hard_nxt;

    // Decoded events for the current cycle
    logic start_match;   // new match begins (start in IDLE or DONE)
    logic lose_ev;       // round lost (lose wins over win)
    logic win_ev;        // round won
    logic hold_exp;      // hold finished (tick count reached or start)
    logic to_done;       // hold finished on the last round of the match

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and event decode
    always_comb begin
        state_d     = state_q;
        start_match = 1'b0;
        lose_ev     = 1'b0;
        win_ev      = 1'b0;
        hold_exp    = 1'b0;
        to_done     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    start_match = 1'b1;
                    state_d     = PLAY;
                end
            end
            PLAY: begin
                // The guess FSM is being cleared while fsm_clr is high, so its
                // flags are stale in that cycle and are not looked at.
                if (!fsm_clr) begin
                    if (lose) begin
                        lose_ev = 1'b1;
                        state_d = RESULT;
                    end else if (win) begin
                        win_ev  = 1'b1;
                        state_d = RESULT;
                    end
                end
            end
            RESULT: begin
                if (start || (en_slow && hold_cnt_q == HOLD_W'(HOLD_TICKS - 1))) begin
                    hold_exp = 1'b1;
                    if (round_cnt_q == SCORE_W'(MATCH_ROUNDS)) begin
                        to_done = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = PLAY;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scores, round counter, result and clear pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wins        <= '0;
            losses      <= '0;
            round_cnt_q <= '0;
            result      <= 2'b00;
            fsm_clr     <= 1'b0;
        end else begin
            fsm_clr <= start_match | (hold_exp & ~to_done);
            if (start_match) begin
                wins        <= '0;
                losses      <= '0;
                round_cnt_q <= '0;
                result      <= 2'b00;
            end else if (lose_ev) begin
                losses      <= (losses == '1) ? losses : losses + 1'b1;
                round_cnt_q <= (round_cnt_q == '1) ? round_cnt_q : round_cnt_q + 1'b1;
                result      <= 2'b10;
            end else if (win_ev) begin
                wins        <= (wins == '1) ? wins : wins + 1'b1;
                round_cnt_q <= (round_cnt_q == '1) ? round_cnt_q : round_cnt_q + 1'b1;
                result      <= 2'b01;
            end else if (hold_exp) begin
                if (to_done) result <= (wins > losses) ? 2'b01 : 2'b10;
                else         result <= 2'b00;
            end
        end
    end

    // Hold counter: counts slow ticks only while a result is displayed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  hold_cnt_q <= '0;
        else if (state_q != RESULT)  hold_cnt_q <= '0;
        else if (en_slow)            hold_cnt_q <= hold_cnt_q + 1'b1;
    end

`ifdef GAME_AUTO_HARD_EN
    localparam int ST_W = $clog2(WIN_STREAK + 1);

    logic [ST_W-1:0] streak_q, streak_nxt;
    logic            auto_hard_q;

    // Streak and auto-hard next values (saturating streak)
    always_comb begin
        streak_nxt    = streak_q;
        auto_hard_nxt = auto_hard_q;
        if (start_match || lose_ev) begin
            streak_nxt    = '0;
            auto_hard_nxt = 1'b0;
        end else if (win_ev) begin
            if (streak_q != '1) streak_nxt = streak_q + 1'b1;
            if (int'(streak_nxt) >= WIN_STREAK) auto_hard_nxt = 1'b1;
        end
    end

    // Streak and auto-hard registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q    <= '0;
            auto_hard_q <= 1'b0;
        end else begin
            streak_q    <= streak_nxt;
            auto_hard_q <= auto_hard_nxt;
        end
    end
`else
    // No streak logic in this build; the expression is a constant 0.
    assign auto_hard_nxt = (WIN_STREAK < 0);
`endif

    // Difficulty register; the tick mux below sees it one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hard_mode <= 1'b0;
        else        hard_mode <= hard_sw | auto_hard_nxt;
    end

    // Speed tick gating and state decode
    always_comb begin
        fsm_en    = (state_q == PLAY) & (hard_mode ? en_fast : en_slow);
        playing   = (state_q == PLAY);
        state_dbg = state_q;
    end

endmodule
